// File: rtl/io_write_guard.sv
// Unlockable per-region write-enable mask behind one Z80 I/O port.
// Optional idle auto-relock: define IO_WRITE_GUARD_TIMEOUT_EN.
module io_write_guard #(
  parameter int                  NREGIONS    = 4,
  parameter logic [7:0]          IO_PORT     = 8'hEF,
  parameter logic [7:0]          KEY0        = 8'hA5,
  parameter logic [7:0]          KEY1        = 8'h5A,
  parameter logic [NREGIONS-1:0] WEN_RESET   = '0,
  parameter int                  TIMEOUT_CYC = 65000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [15:0]         a,
  input  logic                iorq_n,
  input  logic                mreq_n,
  input  logic                rd_n,
  input  logic                wr_n,
  input  logic [7:0]          din,
  output logic [7:0]          dout,
  output logic                dout_oe,
  output logic [NREGIONS-1:0] region_we,
  output logic [NREGIONS-1:0] wen,
  output logic                unlocked
);

  typedef enum logic [1:0] {
    LOCKED   = 2'd0,
    ARMED    = 2'd1,
    UNLOCKED = 2'd2
  } state_t;

  state_t              state, state_nxt;
  logic [NREGIONS-1:0] wen_q, wen_nxt;
  logic                idle_q;
  logic                rst_hold;
  logic                hit;
  logic                strobe_idle;
  logic                pw;
  logic                expire;
  logic                unused_hi;

  assign unused_hi   = ^a[15:8];
  assign hit         = (a[7:0] == IO_PORT);
  assign strobe_idle = iorq_n | wr_n;
  assign pw = ~iorq_n & ~wr_n & hit & idle_q & ~rst_hold;

  // rst_hold masks a strobe already held when reset is released
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= LOCKED;
      wen_q    <= WEN_RESET;
      idle_q   <= 1'b1;
      rst_hold <= 1'b1;
    end else begin
      state    <= state_nxt;
      wen_q    <= wen_nxt;
      idle_q   <= strobe_idle;
      rst_hold <= rst_hold & ~strobe_idle;
    end
  end

`ifdef IO_WRITE_GUARD_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC);
  logic [CW-1:0] cnt;

  // lock on the edge at which the idle count reaches TIMEOUT_CYC-1
  assign expire = (state != LOCKED) &&
                  (cnt == CW'(TIMEOUT_CYC - 2));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      cnt <= '0;
    else if (pw || state_nxt == LOCKED)
      cnt <= '0;
    else
      cnt <= cnt + CW'(1);
  end
`else
  localparam int UNUSED_TMO = TIMEOUT_CYC;
  assign expire = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    wen_nxt   = wen_q;
    if (pw) begin
      unique case (state)
        LOCKED: begin
          if (din == KEY0) state_nxt = ARMED;
        end
        ARMED: begin
          if (din == KEY1)      state_nxt = UNLOCKED;
          else if (din == KEY0) state_nxt = ARMED;
          else                  state_nxt = LOCKED;
        end
        UNLOCKED: begin
          if (din[7]) state_nxt = LOCKED;
          else        wen_nxt   = din[NREGIONS-1:0];
        end
        default: state_nxt = LOCKED;
      endcase
    end else if (expire) begin
      state_nxt = LOCKED;
    end
  end

  always_comb begin
    dout = '0;
    dout[NREGIONS-1:0] = wen_q;
    if (NREGIONS < 7) dout[6] = (state == ARMED);
    dout[7] = (state == UNLOCKED);
  end

  assign dout_oe   = ~iorq_n & ~rd_n & hit;
  assign region_we = {NREGIONS{~mreq_n & ~wr_n}} & wen_q;
  assign wen       = wen_q;
  assign unlocked  = (state == UNLOCKED);

endmodule

// File: tb/tb_io_write_guard.sv
// Directed bench for io_write_guard: vector table plus corner sequences.
// Timeout checks follow IO_WRITE_GUARD_TIMEOUT_EN.
module tb_io_write_guard;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] a;
  logic        iorq_n, mreq_n, rd_n, wr_n;
  logic [7:0]  din;
  logic [7:0]  dout;
  logic        dout_oe;
  logic [3:0]  region_we;
  logic [3:0]  wen;
  logic        unlocked;

  int total = 0;
  int bad   = 0;

  io_write_guard #(
    .NREGIONS(4),
    .IO_PORT(8'hEF),
    .KEY0(8'hA5),
    .KEY1(8'h5A),
    .WEN_RESET(4'b0001),
    .TIMEOUT_CYC(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .a(a),
    .iorq_n(iorq_n),
    .mreq_n(mreq_n),
    .rd_n(rd_n),
    .wr_n(wr_n),
    .din(din),
    .dout(dout),
    .dout_oe(dout_oe),
    .region_we(region_we),
    .wen(wen),
    .unlocked(unlocked)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       is_in;
    logic [7:0] port;
    logic [7:0] data;
    logic [8:0] exp;
  } vec_t;

  vec_t v[24];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic bus_idle();
    a = 16'h0000; iorq_n = 1'b1; mreq_n = 1'b1;
    rd_n = 1'b1; wr_n = 1'b1; din = 8'h00;
  endtask

  task automatic io_out(input logic [7:0] port, input logic [7:0] d);
    a = {8'h12, port}; din = d; iorq_n = 1'b0; wr_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 iorq_n = 1'b1; wr_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic io_in(input logic [7:0] port, output logic [8:0] r);
    a = {8'h34, port}; iorq_n = 1'b0; rd_n = 1'b0;
    #2 r = {dout_oe, dout};
    @(posedge clk);
    #1 iorq_n = 1'b1; rd_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [8:0] r;
    bus_idle();
    reset = 1'b0;

    v[0]  = '{1'b1, 8'hEF, 8'h00, 9'h101};
    v[1]  = '{1'b0, 8'hEF, 8'hA5, 9'h001};
    v[2]  = '{1'b1, 8'hEF, 8'h00, 9'h141};
    v[3]  = '{1'b0, 8'hEF, 8'hA5, 9'h001};
    v[4]  = '{1'b1, 8'hEF, 8'h00, 9'h141};
    v[5]  = '{1'b0, 8'hEF, 8'h5A, 9'h011};
    v[6]  = '{1'b1, 8'hEF, 8'h00, 9'h181};
    v[7]  = '{1'b0, 8'hEF, 8'h05, 9'h015};
    v[8]  = '{1'b1, 8'hEF, 8'h00, 9'h185};
    v[9]  = '{1'b0, 8'hEF, 8'h80, 9'h005};
    v[10] = '{1'b1, 8'hEF, 8'h00, 9'h105};
    v[11] = '{1'b0, 8'hEF, 8'h0F, 9'h005};
    v[12] = '{1'b0, 8'hEF, 8'hA5, 9'h005};
    v[13] = '{1'b0, 8'hEF, 8'h33, 9'h005};
    v[14] = '{1'b1, 8'hEF, 8'h00, 9'h105};
    v[15] = '{1'b0, 8'hEF, 8'h5A, 9'h005};
    v[16] = '{1'b0, 8'hEF, 8'h0F, 9'h005};
    v[17] = '{1'b0, 8'hEE, 8'hA5, 9'h005};
    v[18] = '{1'b1, 8'hEF, 8'h00, 9'h105};
    v[19] = '{1'b1, 8'hEE, 8'h00, 9'h005};
    v[20] = '{1'b0, 8'hEF, 8'hA5, 9'h005};
    v[21] = '{1'b0, 8'hEF, 8'h5A, 9'h015};
    v[22] = '{1'b0, 8'hEF, 8'h01, 9'h011};
    v[23] = '{1'b0, 8'hEF, 8'h80, 9'h001};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_wen", wen, 4'b0001);
    chk("rst_unl", unlocked, 1'b0);
    chk("rst_oe", dout_oe, 1'b0);
    chk("rst_rwe", region_we, 4'b0000);
    reset = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 24; i++) begin
      if (v[i].is_in) begin
        io_in(v[i].port, r);
        chk($sformatf("vec%0d_in", i), r, v[i].exp);
      end else begin
        io_out(v[i].port, v[i].data);
        chk($sformatf("vec%0d_out", i), {3'b000, unlocked, wen},
            v[i].exp);
      end
    end

    // memory write at the port address: gated mask, never a pw
    a = 16'h00EF; din = 8'hA5; mreq_n = 1'b0; wr_n = 1'b0;
    #2 chk("memw_rwe0", region_we, 4'b0001);
    repeat (3) @(posedge clk);
    #1 chk("memw_rwe1", region_we, 4'b0001);
    mreq_n = 1'b1; wr_n = 1'b1;
    #1 chk("memw_off", region_we, 4'b0000);
    @(posedge clk);
    #1 chk("memw_nopw", dout, 8'h01);

    // held strobe: a second pw would load wen with 0xA
    io_out(8'hEF, 8'hA5);
    a = 16'h00EF; din = 8'h5A; iorq_n = 1'b0; wr_n = 1'b0;
    repeat (10) @(posedge clk);
    #1 chk("held_state", {3'b000, unlocked, wen}, 8'h11);
    iorq_n = 1'b1; wr_n = 1'b1;
    @(posedge clk);
    #1;
    io_out(8'hEF, 8'h06);
    chk("held_wen6", wen, 4'h6);
    io_out(8'hEF, 8'h80);
    chk("relock", unlocked, 1'b0);

    // reset while ARMED with a strobe held
    io_out(8'hEF, 8'hA5);
    a = 16'h00EF; din = 8'hA5; iorq_n = 1'b0; wr_n = 1'b0;
    @(posedge clk);
    #1 chk("pre_rst_armed", dout, 8'h46);
    reset = 1'b0;
    #1 chk("async_rst", {unlocked, wen, dout}, {1'b0, 4'h1, 8'h01});
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk("rst_held_nopw", dout, 8'h01);
    iorq_n = 1'b1; wr_n = 1'b1;
    @(posedge clk);
    #1 iorq_n = 1'b0; wr_n = 1'b0;
    @(posedge clk);
    #1 chk("rst_repw", dout, 8'h41);
    iorq_n = 1'b1; wr_n = 1'b1;
    @(posedge clk);
    #1;
    io_out(8'hEF, 8'h00);
    chk("rst_relock", dout, 8'h01);

`ifdef IO_WRITE_GUARD_TIMEOUT_EN
    io_out(8'hEF, 8'hA5);
    a = 16'h00EF; din = 8'h5A; iorq_n = 1'b0; wr_n = 1'b0;
    @(posedge clk);
    #1 iorq_n = 1'b1; wr_n = 1'b1;
    repeat (14) @(posedge clk);
    #1 chk("tmo_before", unlocked, 1'b1);
    @(posedge clk);
    #1 chk("tmo_expire", {unlocked, wen}, {1'b0, 4'h1});
    io_out(8'hEF, 8'hA5);
    a = 16'h00EF; din = 8'h5A; iorq_n = 1'b0; wr_n = 1'b0;
    @(posedge clk);
    #1 iorq_n = 1'b1; wr_n = 1'b1;
    repeat (14) @(posedge clk);
    #1 din = 8'h03; iorq_n = 1'b0; wr_n = 1'b0;
    @(posedge clk);
    #1 chk("tmo_pw_wins", {unlocked, wen}, {1'b1, 4'h3});
    iorq_n = 1'b1; wr_n = 1'b1;
    repeat (14) @(posedge clk);
    #1 chk("tmo_restart", unlocked, 1'b1);
    @(posedge clk);
    #1 chk("tmo_expire2", {unlocked, wen}, {1'b0, 4'h3});
`else
    io_out(8'hEF, 8'hA5);
    io_out(8'hEF, 8'h5A);
    repeat (40) @(posedge clk);
    #1 chk("no_tmo", {unlocked, wen}, {1'b1, 4'h1});
    io_out(8'hEF, 8'h80);
    chk("no_tmo_relock", unlocked, 1'b0);
`endif

    bus_idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
